cmp_result_monitor: RTL

- Downstream consumer of the 4-bit magnitude comparator's three result flags (greater / less / equal).
- Accepts one result per valid/ready transfer.
- Keeps saturating per-category counts, tracks equal-result runs, and flags illegal flag encodings.
- Publishes a frozen snapshot of its counts over a valid/ready output handshake for a host or scoreboard.

---
 rtl/cmp_mon_pkg.sv | 31 +++
 rtl/sat_counter.sv | 20 ++
 rtl/cmp_result_monitor.sv | 111 +++++++++++
 3 files changed

// File: rtl/cmp_mon_pkg.sv
// Shared types and helpers for the comparator result monitor.
// decode_flags folds the three raw comparator flags into one result kind.
package cmp_mon_pkg;

   typedef enum logic [1:0] {
      COUNT  = 2'd0,
      CLEAR  = 2'd1,
      REPORT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      KIND_GT  = 2'd0,
      KIND_LT  = 2'd1,
      KIND_EQ  = 2'd2,
      KIND_BAD = 2'd3
   } cmp_kind_t;

   // Anything other than exactly one flag set is an illegal encoding.
   function automatic cmp_kind_t decode_flags(input logic great, input logic less,
                                              input logic equal);
      cmp_kind_t kind;
      case ({great, less, equal})
         3'b100:  kind = KIND_GT;
         3'b010:  kind = KIND_LT;
         3'b001:  kind = KIND_EQ;
         default: kind = KIND_BAD;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// The count holds at all-ones rather than wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/cmp_result_monitor.sv
// Consumes comparator result flags, keeps saturating statistics and an
// equal-run tracker, and publishes a frozen snapshot over valid/ready.
module cmp_result_monitor
   import cmp_mon_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int RUN_W    = 4,
   parameter int STREAK_N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_great,
   input  logic             a_less,
   input  logic             a_equal,
   input  logic             clear,
   input  logic             snap_req,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [CNT_W-1:0] gt_count,
   output logic [CNT_W-1:0] lt_count,
   output logic [CNT_W-1:0] eq_count,
   output logic [RUN_W-1:0] eq_run_max,
   output logic             streak_hit,
   output logic             onehot_err
);

   localparam logic [RUN_W-1:0] STREAK_V = RUN_W'(STREAK_N);

   state_t           state;
   cmp_kind_t        kind;
   logic             accept;
   logic             liveClr;
   logic [CNT_W-1:0] gtLive, ltLive, eqLive;
   logic [RUN_W-1:0] eqRun, eqRunNext, eqRunMaxLive;

   assign kind       = decode_flags(a_great, a_less, a_equal);
   assign in_ready   = (state != CLEAR);
   assign snap_valid = (state == REPORT);
   assign accept     = in_valid && in_ready;
   assign liveClr    = (state == CLEAR);
   assign eqRunNext  = (eqRun == '1) ? eqRun : eqRun + 1'b1;

   sat_counter #(.W(CNT_W)) uGtCnt (
      .clk(clk), .rst(rst), .clr(liveClr), .inc(accept && (kind == KIND_GT)), .q(gtLive)
   );
   sat_counter #(.W(CNT_W)) uLtCnt (
      .clk(clk), .rst(rst), .clr(liveClr), .inc(accept && (kind == KIND_LT)), .q(ltLive)
   );
   sat_counter #(.W(CNT_W)) uEqCnt (
      .clk(clk), .rst(rst), .clr(liveClr), .inc(accept && (kind == KIND_EQ)), .q(eqLive)
   );

   // Capture samples the live values before this edge's result lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= COUNT;
         gt_count   <= '0;
         lt_count   <= '0;
         eq_count   <= '0;
         eq_run_max <= '0;
      end else begin
         case (state)
            COUNT: begin
               if (clear) begin
                  state <= CLEAR;
               end else if (snap_req) begin
                  state      <= REPORT;
                  gt_count   <= gtLive;
                  lt_count   <= ltLive;
                  eq_count   <= eqLive;
                  eq_run_max <= eqRunMaxLive;
               end
            end
            CLEAR:   state <= COUNT;
            REPORT:  if (snap_ready) state <= COUNT;
            default: state <= COUNT;
         endcase
      end
   end

   // The streak fires only on the step into STREAK_N, so a saturated run
   // sitting at STREAK_N does not retrigger.
   always_ff @(posedge clk) begin
      if (rst || liveClr) begin
         eqRun        <= '0;
         eqRunMaxLive <= '0;
         streak_hit   <= 1'b0;
         onehot_err   <= 1'b0;
      end else begin
         streak_hit <= 1'b0;
         if (accept) begin
            case (kind)
               KIND_EQ: begin
                  eqRun <= eqRunNext;
                  if (eqRunNext > eqRunMaxLive)
                     eqRunMaxLive <= eqRunNext;
                  streak_hit <= (eqRunNext == STREAK_V) && (eqRun != STREAK_V);
               end
               KIND_GT, KIND_LT: eqRun <= '0;
               default: begin
                  eqRun      <= '0;
                  onehot_err <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
